// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: drives the fetch/BTB lookup PC, queues BTB predictions
// in program order and redirects fetch when execute reports a mispredicted branch.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,
    input  logic        btb_link,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_link,
    output logic [31:0] current_pc,
    output logic        btb_enable,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic        out_pred_taken,
    output logic        flush,
    output logic        btb_do_write,
    output logic [31:0] btb_wr_pc,
    output logic [31:0] btb_wr_target,
    output logic        btb_wr_link
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   lk_pc;
    logic          lk_valid;

    logic [31:0]   q_pc     [QDEPTH];
    logic          q_taken  [QDEPTH];
    logic [31:0]   q_target [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [31:0]   head_pc;
    logic [31:0]   head_pc4;
    logic          head_taken;
    logic [31:0]   head_target;
    logic          pop;
    logic          wrong;
    logic          redirect;
    logic          need_write;
    logic [CW-1:0] occupancy;
    logic          advance;
    logic          predict_taken;
    logic          push;

    // The link flag is only carried by the BTB entry itself; fetch does not use it.
    logic          unused_link;
    assign unused_link = btb_link;

    always_comb begin
        head_pc       = q_pc[head];
        head_taken    = q_taken[head];
        head_target   = q_target[head];
        head_pc4      = head_pc + 32'd4;
        pop           = ex_valid && (count != '0);
        wrong         = ex_is_branch
                        ? ((ex_taken != head_taken) || (ex_taken && (ex_target != head_target)))
                        : head_taken;
        redirect      = pop && wrong;
        need_write    = pop && ex_is_branch && ex_taken
                        && (!head_taken || (ex_target != head_target));
        // The lookup stage already holds a slot, so it counts toward occupancy.
        occupancy     = count + CW'(lk_valid);
        advance       = !stall && (occupancy < CW'(QDEPTH));
        predict_taken = lk_valid && btb_hit;
        push          = lk_valid && advance && !redirect;
    end

    assign out_valid      = lk_valid;
    assign out_pc         = lk_pc;
    assign out_pred_taken = predict_taken;
    assign btb_enable     = !stall || btb_do_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            current_pc    <= RESET_PC;
            lk_pc         <= 32'd0;
            lk_valid      <= 1'b0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            flush         <= 1'b0;
            btb_do_write  <= 1'b0;
            btb_wr_pc     <= 32'd0;
            btb_wr_target <= 32'd0;
            btb_wr_link   <= 1'b0;
        end else begin
            flush        <= redirect;
            btb_do_write <= need_write;
            if (need_write) begin
                btb_wr_pc     <= head_pc4;
                btb_wr_target <= ex_target;
                btb_wr_link   <= ex_link;
            end
            if (redirect) begin
                current_pc <= ex_taken ? ex_target : head_pc4;
                lk_valid   <= 1'b0;
                head       <= '0;
                tail       <= '0;
                count      <= '0;
            end else begin
                if (advance) begin
                    // A taken prediction kills the sequential fetch now in flight.
                    lk_pc      <= current_pc;
                    lk_valid   <= !predict_taken;
                    current_pc <= predict_taken ? btb_target : current_pc + 32'd4;
                end
                if (push)
                    tail <= tail + PW'(1);
                if (pop)
                    head <= head + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push && !redirect) begin
            q_pc[tail]     <= lk_pc;
            q_taken[tail]  <= predict_taken;
            q_target[tail] <= predict_taken ? btb_target : lk_pc + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && ex_valid)
            assert (count != '0) else $error("fetch_pc_ctrl: ex_valid with empty prediction queue");
    end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage PC controller that drives the instruction-fetch address and the branch-target buffer (BTB) lookup PC every cycle. It consumes the BTB's registered prediction, records it in an in-order prediction queue, and compares it against branch resolution from execute. On a wrong prediction it redirects fetch, pulses a pipeline flush and issues a BTB update. It sits between the BTB and decode.

## Interface

- RESET_PC, 32'h0000_0000, first fetch address after reset
- QDEPTH, 4, prediction-queue depth (power of 2, ≥2)

- clock  in  1  clock, all state on posedge
- reset  in  1  reset, synchronous, active-high
- stall  in  1  downstream backpressure; hold fetch
- btb_hit  in  1  BTB registered hit for the PC presented one cycle earlier
- btb_target  in  32  predicted target
- btb_link  in  1  predicted entry is a jump-and-link
- ex_valid  in  1  oldest in-flight instruction resolves this cycle
- ex_is_branch  in  1  resolved instruction is a branch/jump
- ex_taken  in  1  actual direction
- ex_target  in  32  actual target
- ex_link  in  1  actual instruction is jump-and-link
- current_pc  out  32  fetch address; also BTB lookup PC
- btb_enable  out  1  BTB update/LRU enable (= !stall || btb_do_write)
- out_valid  out  1  out_pc instruction is on the predicted path
- out_pc  out  32  PC of the instruction fetched in the previous cycle
- out_pred_taken  out  1  prediction attached to out_pc
- flush  out  1  one-cycle squash of all younger in-flight instructions
- btb_do_write  out  1  one-cycle BTB allocate request
- btb_wr_pc  out  32  branch PC + 4 (the BTB stores this value − 4)
- btb_wr_target  out  32  target to store
- btb_wr_link  out  1  link flag to store

## Operation

- Two-stage pipeline: fetch stage (`current_pc`) → lookup stage (`lk_pc`, `lk_valid`). The BTB answer for `lk_pc` arrives during the lookup stage.
- Next-PC priority, highest first:
  1. Mispredict redirect.
  2. Stall or queue-full hold.
  3. `btb_hit && lk_valid` → `btb_target`.
  4. `current_pc + 4`.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC + 4 wraps to 0.
- BTB taken prediction while in the lookup stage:
  - The fetch at `current_pc` (sequential, wrong path) is killed, so `lk_valid` is cleared next cycle.
  - The entry for `lk_pc` is pushed with `pred_taken=1` and `pred_target=btb_target`.
- Non-hit lookup: push `{lk_pc, 0, lk_pc+4}`.
- A push occurs when `lk_valid && !stall` and no redirect is active.
- Queue occupancy counts the lookup stage. Fetch advances only if `count + lk_valid < QDEPTH`; otherwise it holds like a stall. There is no full-queue bypass.
- On `ex_valid`, pop the head and evaluate mispredict as follows:
  - Branch: mispredict = `ex_taken != pred_taken || (ex_taken && ex_target != pred_target)`.
  - Non-branch: mispredict = `pred_taken`.
  - `ex_valid` on an empty queue is a protocol error: ignore it and flag it in simulation.
- Mispredict response, next cycle:
  - `current_pc` = `ex_taken ? ex_target : head_pc+4`.
  - Queue emptied, `lk_valid`=0, `flush`=1 for one cycle.
  - Resolution and redirect take effect even under stall.
- BTB write: on a taken branch that was predicted not-taken or with a wrong target, pulse `btb_do_write` with `btb_wr_pc=head_pc+4`, `btb_wr_target=ex_target`, `btb_wr_link=ex_link`. Stale entries are never invalidated.
- Pop and push in the same cycle are allowed and leave the count unchanged.

## Timing

- Reset values: `current_pc=RESET_PC`, `lk_valid=0`, queue empty, `out_valid=0`, `out_pc=0`, `out_pred_taken=0`, `flush=0`, `btb_do_write=0`, `btb_wr_*=0`.
- First fetch at RESET_PC in the first cycle after reset deasserts; its `out_valid` appears one cycle later.
- Sequential fetch rate is 1 PC per cycle.
- BTB-taken penalty is 1 killed slot.
- Mispredict latency: resolution cycle → correct `current_pc` in the next cycle.
- `flush` and `btb_do_write` are registered and assert in the same cycle as the redirected PC.
- Reset mid-operation discards the queue and any pending write or flush; the next cycle behaves as after power-on.

## Test plan

- Reset, no stall, no BTB hits → `current_pc` 0,4,8,12 on consecutive cycles; `out_valid` with `out_pc` 0,4,8 one cycle behind; all outputs 0 during reset.
- BTB hit for 0x8 with target 0x40 → `current_pc` 0,4,8,0xC,0x40; `out_pc` 0xC has `out_valid`=0; `out_pc` 0x8 has `out_pred_taken`=1.
- Queue holds 0x10 predicted not-taken; ex resolves it taken to 0x80 → next cycle `current_pc`=0x80, `flush`=1, `btb_do_write`=1, `btb_wr_pc`=0x14, `btb_wr_target`=0x80; queue empty.
- Non-branch at 0x20 predicted taken → redirect to 0x24, `flush`=1, `btb_do_write`=0.
- `ex_valid` held low with QDEPTH=4 → PC holds after 4 outstanding; one `ex_valid` with a correct prediction → exactly one new PC advance.
- `stall` high for 3 cycles with `btb_hit` present → PC, `lk_pc` and queue frozen; the hit is honoured on release; reset asserted mid-stall → `current_pc`=RESET_PC next cycle.
